product_drain: RTL and testbench
================================

// Module: product_drain
// PURPOSE
//  Downstream stage of the product register array. On start, reads the DIM_C x DIM_A
//  accumulator matrix row by row, narrows each element ACC_WIDTH->OUT_WIDTH and streams
//  one row per beat on a valid/ready interface to the writeback buffer. busy tells the
//  upstream controller to hold the product-register enables low while rows are read.
// PARAMETERS
//  DIM_C      16  rows in product matrix (beats per drain)
//  DIM_A      32  elements per row
//  ACC_WIDTH  32  signed accumulator width of each input element
//  OUT_WIDTH  16  signed width of each output element (OUT_WIDTH <= ACC_WIDTH)
// PORTS
//  clk        in   1                          clock, all state on posedge
//  rst_n      in   1                          reset, asynchronous, active-low
//  start      in   1                          pulse: begin draining matrix
//  prod_in    in   [DIM_C][DIM_A][ACC_WIDTH]  registered product matrix (held stable while busy)
//  busy       out  1                          high from accepted start until done
//  out_valid  out  1                          output beat valid
//  out_ready  in   1                          consumer accepts beat
//  out_data   out  [DIM_A][OUT_WIDTH]         narrowed row
//  out_row    out  $clog2(DIM_C)              row index of current beat
//  out_last   out  1                          beat is row DIM_C-1
//  done       out  1                          one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, out_valid=0, out_data=0, out_row=0, out_last=0, done=0, row_cnt=0.
//  FSM IDLE -> LOAD -> STREAM -> DONE -> IDLE.
//   IDLE:   start=1 -> LOAD, busy=1 next cycle, row_cnt=0. start=0 -> stay.
//   LOAD:   register narrow(prod_in[row_cnt]) into out_data, out_row=row_cnt,
//           out_last=(row_cnt==DIM_C-1), out_valid=1; -> STREAM. Latency start->out_valid = 2 cycles.
//   STREAM: out_valid&out_ready: if out_last -> out_valid=0, DONE; else row_cnt+1 and next row
//           loaded in same edge (back-to-back beats, one row/cycle at full throughput).
//           out_valid&!out_ready: out_data/out_row/out_last held bit-stable; out_valid never drops.
//   DONE:   done=1 for exactly one cycle, busy=0 on the same cycle's exit edge -> IDLE.
//  start outside IDLE ignored (no queuing). start in DONE cycle ignored; next start needs IDLE.
//  busy=1 in LOAD, STREAM, DONE; upstream must not write product registers while busy=1.
//  row_cnt never wraps: terminal count DIM_C-1 ends the drain; DIM_C=1 gives single beat with out_last=1.
//  Narrowing (per element, signed): default = truncate, keep bits [OUT_WIDTH-1:0].
//  OUT_WIDTH==ACC_WIDTH: pass-through, no narrowing.
//  rst_n asserted mid-drain: immediate return to reset values; partial row is lost, no done pulse.
//  Exactly DIM_C beats per start, rows in ascending order 0..DIM_C-1.
// CONFIGURATION
//  PRODUCT_DRAIN_SAT_EN defined: signed saturation to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
//   instead of truncation; adds output sat_flag (1 bit): OR of all element saturations of the
//   current beat, valid and held with out_data, reset 0.
//  Not defined: truncation only; sat_flag port absent. Cycle timing identical in both builds.
// STRUCTURE
//  Package product_drain_pkg: state enum drain_state_e {IDLE,LOAD,STREAM,DONE};
//   function narrow_elem(acc) (trunc or sat per macro); localparam ROW_IDX_W=$clog2(DIM_C) (min 1).
//  Sub-module product_row_narrow: combinational, applies narrow_elem to DIM_A elements of one row,
//   emits narrowed row + row saturation OR. FSM, row counter and output register in product_drain.
// TESTING
//  1 Reset then idle 10 cycles, start=0 -> busy=0, out_valid=0, done=0 throughout.
//  2 prod_in[r][a]=r*100+a, start, out_ready=1 -> 16 back-to-back beats rows 0..15,
//    out_data[a]=r*100+a, out_last only on row 15, done one cycle after, busy low after.
//  3 out_ready toggled randomly, stalls of 1-5 cycles -> data/row held stable while stalled,
//    no beat lost or duplicated, exactly 16 handshakes.
//  4 prod_in elem=32'h0001_8000 / 32'hFFFE_0001 -> trunc build: 16'h8000 / 16'h0001;
//    SAT_EN build: 16'h7FFF / 16'h8000 and sat_flag=1; elem=-5 -> 16'hFFFB, sat_flag=0.
//  5 start pulsed during STREAM and in DONE cycle -> ignored, still exactly 16 beats, one done.
//  6 rst_n low at beat 7 -> all outputs to reset values asynchronously; new start drains from row 0.

Source files
------------

// File: rtl/product_drain_pkg.sv
// Shared configuration, FSM state type and element narrowing for the product drain.
// PRODUCT_DRAIN_SAT_EN selects signed saturation instead of truncation.
package product_drain_pkg;

    localparam int DIM_C     = 16;
    localparam int DIM_A     = 32;
    localparam int ACC_WIDTH = 32;
    localparam int OUT_WIDTH = 16;
    localparam int ROW_IDX_W = (DIM_C > 1) ? $clog2(DIM_C) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} drain_state_e;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 sat;
    } narrow_t;

    function automatic narrow_t narrow_elem(input logic [ACC_WIDTH-1:0] acc);
        narrow_t r;
        r.data = acc[OUT_WIDTH-1:0];
        r.sat  = 1'b0;
`ifdef PRODUCT_DRAIN_SAT_EN
        // In range iff every bit from the output sign bit upward matches.
        if (!((&acc[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|acc[ACC_WIDTH-1:OUT_WIDTH-1]))) begin
            r.sat  = 1'b1;
            r.data = acc[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/product_row_narrow.sv
// Combinational narrowing of one accumulator row to the output element width.
// With PRODUCT_DRAIN_SAT_EN it also reports whether any element saturated.
module product_row_narrow
    import product_drain_pkg::*;
(
    input  logic [DIM_A-1:0][ACC_WIDTH-1:0] row,
`ifdef PRODUCT_DRAIN_SAT_EN
    output logic                            row_sat,
`endif
    output logic [DIM_A-1:0][OUT_WIDTH-1:0] row_out
);

    logic [DIM_A-1:0] sat_vec;

    for (genvar a = 0; a < DIM_A; a++) begin : g_elem
        narrow_t n;
        assign n          = narrow_elem(row[a]);
        assign row_out[a] = n.data;
        assign sat_vec[a] = n.sat;
    end

`ifdef PRODUCT_DRAIN_SAT_EN
    assign row_sat = |sat_vec;
`else
    logic unused_sat;
    assign unused_sat = ^sat_vec;
`endif

endmodule

// File: rtl/product_drain.sv
// Drains the product matrix row by row onto a valid/ready stream, one row per beat.
// PRODUCT_DRAIN_SAT_EN adds saturating narrowing and the sat_flag output.
module product_drain
    import product_drain_pkg::*;
(
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] prod_in,
    output logic                                       busy,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [DIM_A-1:0][OUT_WIDTH-1:0]            out_data,
    output logic [ROW_IDX_W-1:0]                       out_row,
    output logic                                       out_last,
`ifdef PRODUCT_DRAIN_SAT_EN
    output logic                                       sat_flag,
`endif
    output logic                                       done
);

    localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(DIM_C - 1);

    drain_state_e                  state, state_nxt;
    logic [ROW_IDX_W-1:0]          row_cnt, row_sel;
    logic                          load_row, clr_row, drop_valid;
    logic [DIM_A-1:0][OUT_WIDTH-1:0] row_narrow;
`ifdef PRODUCT_DRAIN_SAT_EN
    logic                          row_sat;
`endif

    product_row_narrow u_narrow (
        .row     (prod_in[row_sel]),
`ifdef PRODUCT_DRAIN_SAT_EN
        .row_sat (row_sat),
`endif
        .row_out (row_narrow)
    );

    always_comb begin
        state_nxt  = state;
        load_row   = 1'b0;
        clr_row    = 1'b0;
        drop_valid = 1'b0;
        row_sel    = row_cnt;
        unique case (state)
            IDLE: if (start) begin
                state_nxt = LOAD;
                clr_row   = 1'b1;
            end
            LOAD: begin
                load_row  = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: if (out_valid && out_ready) begin
                if (out_last) begin
                    drop_valid = 1'b1;
                    state_nxt  = DONE;
                end else begin
                    // Next row is fetched on the accepting edge for back-to-back beats.
                    row_sel  = row_cnt + 1'b1;
                    load_row = 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
`ifdef PRODUCT_DRAIN_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (clr_row) row_cnt <= '0;
            else if (load_row) row_cnt <= row_sel;
            if (load_row) begin
                out_valid <= 1'b1;
                out_data  <= row_narrow;
                out_row   <= row_sel;
                out_last  <= (row_sel == ROW_LAST);
`ifdef PRODUCT_DRAIN_SAT_EN
                sat_flag  <= row_sat;
`endif
            end else if (drop_valid) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_product_drain.sv
// Directed self-checking bench for product_drain: idle, full drains, stalls,
// narrowing corner values, ignored start pulses and mid-drain reset.
module tb_product_drain;
    import product_drain_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] prod_in = '0;
    logic busy, out_valid, out_last, done;
    logic [DIM_A-1:0][OUT_WIDTH-1:0] out_data;
    logic [ROW_IDX_W-1:0] out_row;
`ifdef PRODUCT_DRAIN_SAT_EN
    logic sat_flag;
`endif

    int n_assert = 0, n_fail = 0;

    product_drain dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prod_in(prod_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_last(out_last),
`ifdef PRODUCT_DRAIN_SAT_EN
        .sat_flag(sat_flag),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_WIDTH-1:0] model_narrow(input logic [ACC_WIDTH-1:0] acc, output logic sat);
        longint v;
        v   = longint'($signed(acc));
        sat = 1'b0;
`ifdef PRODUCT_DRAIN_SAT_EN
        if (v > 32767)  begin sat = 1'b1; return 16'h7FFF; end
        if (v < -32768) begin sat = 1'b1; return 16'h8000; end
`endif
        return acc[OUT_WIDTH-1:0];
    endfunction

    // mode 0: always ready; 1: random stalls of 1-5 cycles; 2: always ready plus stray start pulses
    task automatic run_drain(input int mode, input string name);
        int beats = 0, dones = 0, cyc = 0, stall_left = 0;
        bit held = 0, poke_done = 0;
        logic [DIM_A-1:0][OUT_WIDTH-1:0] held_data, exp_row;
        logic [ROW_IDX_W-1:0] held_row;
        logic held_last, s, rs;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({name, "_busy_after_start"}, 512'(busy), 512'(1));
        chk({name, "_valid_latency"}, 512'(out_valid), 512'(0));
        while (dones == 0 && cyc < 400) begin
            @(negedge clk); cyc++;
            start = (mode == 2 && beats == 5 && cyc < 20) ? 1'b1 : 1'b0;
            if (done) begin
                dones++;
                chk({name, "_beats_at_done"}, 512'(beats), 512'(DIM_C));
                chk({name, "_valid_at_done"}, 512'(out_valid), 512'(0));
                chk({name, "_busy_at_done"}, 512'(busy), 512'(1));
                if (mode == 2) start = 1'b1;
                break;
            end
            if (mode == 1) begin
                if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
                else begin
                    out_ready = 1'b1;
                    if ($urandom_range(0, 1) == 1) stall_left = $urandom_range(1, 5);
                end
            end else out_ready = 1'b1;
            if (out_valid) begin
                if (held) begin
                    if (out_data !== held_data || out_row !== held_row || out_last !== held_last)
                        chk({name, "_stall_hold"}, {out_row, out_last, 1'b0}, {held_row, held_last, 1'b1});
                end
                if (out_ready) begin
                    chk({name, "_row"}, 512'(out_row), 512'(beats));
                    chk({name, "_last"}, 512'(out_last), 512'(beats == DIM_C - 1));
                    rs = 1'b0;
                    for (int a = 0; a < DIM_A; a++) begin
                        exp_row[a] = model_narrow(prod_in[beats][a], s);
                        rs |= s;
                    end
                    chk({name, "_data"}, 512'(out_data), 512'(exp_row));
`ifdef PRODUCT_DRAIN_SAT_EN
                    chk({name, "_sat_flag"}, 512'(sat_flag), 512'(rs));
`endif
                    beats++; held = 0;
                end else begin
                    held = 1; held_data = out_data; held_row = out_row; held_last = out_last;
                end
            end else if (beats > 0) begin
                chk({name, "_valid_dropped"}, 512'(out_valid), 512'(1));
            end
        end
        if (dones == 0) chk({name, "_done_timeout"}, 512'(cyc), 512'(0));
        @(negedge clk); start = 1'b0;
        chk({name, "_done_one_cycle"}, 512'(done), 512'(0));
        chk({name, "_busy_low_after"}, 512'(busy), 512'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({name, "_no_restart"}, {out_valid, busy, done}, 512'(0));
        end
        poke_done = 1;
        if (!poke_done) chk({name, "_unreached"}, 512'(0), 512'(1));
    endtask

    initial begin
        // 1: reset and idle
        #12;
        chk("reset_outputs", {busy, out_valid, done, out_last, out_row, out_data}, 512'(0));
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", {busy, out_valid, done}, 512'(0));
        end

        // 2: r*100+a, full throughput
        for (int r = 0; r < DIM_C; r++)
            for (int a = 0; a < DIM_A; a++)
                prod_in[r][a] = ACC_WIDTH'(r * 100 + a);
        run_drain(0, "ramp");

        // 3: random stalls
        run_drain(1, "stall");

        // 5: stray start pulses during STREAM and DONE
        run_drain(2, "pokes");

        // 4: narrowing corners; last row only -5
        for (int r = 0; r < DIM_C; r++)
            for (int a = 0; a < DIM_A; a++)
                prod_in[r][a] = (r == DIM_C - 1) ? 32'hFFFF_FFFB :
                                (a % 3 == 0) ? 32'h0001_8000 :
                                (a % 3 == 1) ? 32'hFFFE_0001 : 32'hFFFF_FFFB;
        @(negedge clk); start = 1'b1; out_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
`ifdef PRODUCT_DRAIN_SAT_EN
        chk("narrow_pos_ovf", 512'(out_data[0]), 512'(16'h7FFF));
        chk("narrow_neg_ovf", 512'(out_data[1]), 512'(16'h8000));
        chk("narrow_sat_flag", 512'(sat_flag), 512'(1));
`else
        chk("narrow_pos_trunc", 512'(out_data[0]), 512'(16'h8000));
        chk("narrow_neg_trunc", 512'(out_data[1]), 512'(16'h0001));
`endif
        chk("narrow_minus5", 512'(out_data[2]), 512'(16'hFFFB));
        rst_n = 1'b0; #1; rst_n = 1'b1;
        run_drain(0, "narrow");

        // 6: asynchronous reset at beat 7, then a clean drain
        for (int r = 0; r < DIM_C; r++)
            for (int a = 0; a < DIM_A; a++)
                prod_in[r][a] = ACC_WIDTH'(r * 1000 - a * 7);
        @(negedge clk); start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 40 && !(out_valid && out_row == 7); i++) @(negedge clk);
        chk("reach_beat7", {out_valid, 4'(out_row)}, {1'b1, 4'd7});
        #2 rst_n = 1'b0; #1;
        chk("async_reset", {busy, out_valid, done, out_last, out_row, out_data}, 512'(0));
        @(negedge clk);
        chk("reset_no_done", {done, busy}, 512'(0));
        rst_n = 1'b1;
        run_drain(0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
